// File: rtl/stb_gen_mc.sv
// Multi-channel strobe generator whose period is measured from an asynchronous input signal.
// stb_o is registered one cycle after the phase counter; the measured period takes effect at the next counter wrap.
module stb_gen_mc #(
   parameter int unsigned T_CNT_WIDTH      = 32,
   parameter int unsigned AVG_LOG2         = 2,
   parameter int unsigned ZERO_HOLD_CYCLES = 5,
   parameter int unsigned N_CH             = 2,
   parameter logic [T_CNT_WIDTH-1:0] TIMEOUT_CYCLES = {T_CNT_WIDTH{1'b1}}
) (
   input  logic                        clk_i,
   input  logic                        arst_ni,
   input  logic                        sig_i,
   input  logic                        run_det_i,
   input  logic [N_CH-1:0]             oe_i,
   input  logic [N_CH*T_CNT_WIDTH-1:0] phase_i,
   output logic [N_CH-1:0]             stb_o,
   output logic [T_CNT_WIDTH-1:0]      stb_period_o,
   output logic                        rdy_o,
   output logic                        err_o
);

   localparam int unsigned AW = T_CNT_WIDTH + AVG_LOG2;
   localparam int unsigned EW = AVG_LOG2 + 1;
   localparam logic [EW-1:0]          LAST_EDGE = EW'((1 << AVG_LOG2) - 1);
   localparam logic [T_CNT_WIDTH-1:0] ZH        = T_CNT_WIDTH'(ZERO_HOLD_CYCLES);
   localparam logic [T_CNT_WIDTH-1:0] ONE       = T_CNT_WIDTH'(1);

   typedef enum logic [1:0] {ST_GEN, ST_ARM, ST_MEAS, ST_HOLD} state_t;

   state_t                 state_q, state_d;
   logic                   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic                   edge_q, edge_d;
   logic [T_CNT_WIDTH-1:0] cyc_q, cyc_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic [EW-1:0]          ecnt_q, ecnt_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   logic                   rdy_q, rdy_d, err_q, err_d;
   logic [T_CNT_WIDTH-1:0] act_q, act_d;
   logic [T_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]        stb_q, stb_d;

   logic [T_CNT_WIDTH-1:0] cyc_inc;
   logic [AW-1:0]          acc_sum;
   logic [T_CNT_WIDTH-1:0] avg;

   always_comb begin
      sync1_d = sig_i;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      edge_d  = sync2_q & ~sync3_q;
   end

   assign cyc_inc = cyc_q + ONE;
   assign acc_sum = acc_q + AW'(cyc_inc);
   assign avg     = acc_sum[AW-1:AVG_LOG2];

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      acc_d    = acc_q;
      ecnt_d   = ecnt_q;
      period_d = period_q;
      rdy_d    = rdy_q;
      err_d    = err_q;
      case (state_q)
         ST_GEN: begin
            if (run_det_i) begin
               state_d = ST_ARM;
               rdy_d   = 1'b0;
               err_d   = 1'b0;
               cyc_d   = '0;
            end
         end
         ST_ARM: begin
            if (!run_det_i) begin
               state_d = ST_GEN;
               rdy_d   = 1'b1;
               err_d   = 1'b0;
            end else if (edge_q) begin
               state_d = ST_MEAS;
               cyc_d   = '0;
               acc_d   = '0;
               ecnt_d  = '0;
            end else if (cyc_inc == TIMEOUT_CYCLES) begin
               state_d = ST_GEN;
               rdy_d   = 1'b1;
               err_d   = 1'b1;
            end else begin
               cyc_d = cyc_inc;
            end
         end
         ST_MEAS: begin
            if (!run_det_i) begin
               state_d = ST_GEN;
               rdy_d   = 1'b1;
               err_d   = 1'b0;
            end else if (edge_q) begin
               cyc_d  = '0;
               acc_d  = acc_sum;
               ecnt_d = ecnt_q + EW'(1);
               if (ecnt_q == LAST_EDGE) begin
                  rdy_d = 1'b1;
                  // Too short a period would leave no high time in the strobe.
                  if (avg > ZH) begin
                     period_d = avg;
                     state_d  = ST_HOLD;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_GEN;
                  end
               end
            end else if (cyc_inc == TIMEOUT_CYCLES) begin
               state_d = ST_GEN;
               rdy_d   = 1'b1;
               err_d   = 1'b1;
            end else begin
               cyc_d = cyc_inc;
            end
         end
         ST_HOLD: begin
            if (!run_det_i) begin
               state_d = ST_GEN;
            end
         end
         default: state_d = ST_GEN;
      endcase
   end

   // A zero active period counts as wrapping every cycle, so the first period loads at once.
   always_comb begin
      cnt_d = cnt_q + ONE;
      act_d = act_q;
      if ((act_q == '0) || (cnt_q == act_q - ONE)) begin
         cnt_d = '0;
         act_d = period_q;
      end
   end

   always_comb begin
      logic [T_CNT_WIDTH-1:0] ph;
      logic [T_CNT_WIDTH-1:0] ph_eff;
      logic [T_CNT_WIDTH:0]   d;
      logic                   low;
      ph     = '0;
      ph_eff = '0;
      d      = '0;
      low    = 1'b0;
      stb_d  = '0;
      for (int k = 0; k < N_CH; k++) begin
         ph     = phase_i[k*T_CNT_WIDTH +: T_CNT_WIDTH];
         ph_eff = (ph < act_q) ? ph : '0;
         if (cnt_q >= ph_eff) begin
            d = {1'b0, cnt_q} - {1'b0, ph_eff};
         end else begin
            d = {1'b0, cnt_q} + {1'b0, act_q} - {1'b0, ph_eff};
         end
         low      = (act_q != '0) && (d >= ({1'b0, act_q} - {1'b0, ZH}));
         stb_d[k] = ~low & oe_i[k];
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q  <= ST_GEN;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sync3_q  <= 1'b0;
         edge_q   <= 1'b0;
         cyc_q    <= '0;
         acc_q    <= '0;
         ecnt_q   <= '0;
         period_q <= '0;
         rdy_q    <= 1'b1;
         err_q    <= 1'b0;
         act_q    <= '0;
         cnt_q    <= '0;
         stb_q    <= '0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         sync3_q  <= sync3_d;
         edge_q   <= edge_d;
         cyc_q    <= cyc_d;
         acc_q    <= acc_d;
         ecnt_q   <= ecnt_d;
         period_q <= period_d;
         rdy_q    <= rdy_d;
         err_q    <= err_d;
         act_q    <= act_d;
         cnt_q    <= cnt_d;
         stb_q    <= stb_d;
      end
   end

   assign stb_o        = stb_q;
   assign stb_period_o = period_q;
   assign rdy_o        = rdy_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_stb_gen_mc.sv
// Randomised scoreboard bench for stb_gen_mc: measurement results are queued by the stimulus and
// popped on each rising rdy_o; strobes are predicted every cycle from a modulo-arithmetic model.
module tb_stb_gen_mc;
   localparam int TW = 16;
   localparam int ZH = 5;
   localparam logic [15:0] TO = 16'd1000;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        sig = 1'b0;
   logic        run = 1'b0;
   logic [1:0]  oe = 2'b00;
   logic [31:0] phase = '0;
   logic [1:0]  stb_o;
   logic [15:0] stb_period_o;
   logic        rdy_o, err_o;

   stb_gen_mc #(
      .T_CNT_WIDTH(TW), .AVG_LOG2(2), .ZERO_HOLD_CYCLES(ZH), .N_CH(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .arst_ni(arst_n), .sig_i(sig), .run_det_i(run), .oe_i(oe),
      .phase_i(phase), .stb_o(stb_o), .stb_period_o(stb_period_o), .rdy_o(rdy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] period;
      logic        err;
   } res_t;

   res_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   model_period = 0;
   int   pend_p = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [1:0] ref_stb(input int cnt, input int p, input logic [31:0] ph,
                                          input logic [1:0] en);
      logic [1:0] r;
      int phk, d;
      r = en;
      if (p != 0) begin
         for (int k = 0; k < 2; k++) begin
            phk = int'(ph[k*16 +: 16]);
            if (phk >= p) phk = 0;
            d = (cnt - phk + p) % p;
            r[k] = en[k] & (d < p - ZH);
         end
      end
      return r;
   endfunction

   // Monitor: scoreboard pop on completion, strobe prediction every cycle.
   initial begin
      int m_cnt, m_p;
      logic [1:0] exp_stb;
      logic prev_rdy;
      res_t r;
      m_cnt = 0; m_p = 0; exp_stb = 2'b00; prev_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (!arst_n) begin
            m_cnt = 0; m_p = 0; pend_p = 0; exp_stb = 2'b00; prev_rdy = 1'b1;
         end else begin
            if (rdy_o && !prev_rdy) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sb_underflow: rdy_o rose with period %0d err %0d, no result expected",
                           stb_period_o, err_o);
               end else begin
                  r = exp_q.pop_front();
                  check("meas_period", 32'(stb_period_o), 32'(r.period));
                  check("meas_err", 32'(err_o), 32'(r.err));
                  pend_p = int'(r.period);
               end
            end
            prev_rdy = rdy_o;
            check("stb", 32'(stb_o), 32'(exp_stb));
            exp_stb = ref_stb(m_cnt, m_p, phase, oe);
            if (m_p == 0 || m_cnt == m_p - 1) begin
               m_cnt = 0;
               m_p   = pend_p;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_rdy(input string name, input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         tick(1);
         if (rdy_o) got = 1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s: rdy_o still 0 after %0d cycles, want 1", name, lim);
      end
      run = 1'b0;
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      run = 1'b0;
      sig = 1'b0;
      tick(2);
      check("rst_stb", 32'(stb_o), 0);
      check("rst_rdy", 32'(rdy_o), 1);
      check("rst_err", 32'(err_o), 0);
      check("rst_period", 32'(stb_period_o), 0);
      exp_q.delete();
      model_period = 0;
      arst_n = 1'b1;
      tick(1);
   endtask

   task automatic send_edges(input int p0, input int p1, input int p2, input int p3);
      int p[4];
      int h;
      p = '{p0, p1, p2, p3};
      sig = 1'b1;
      for (int i = 0; i < 4; i++) begin
         h = p[i] / 2;
         tick(h);
         sig = 1'b0;
         tick(p[i] - h);
         sig = 1'b1;
      end
      tick(2);
      sig = 1'b0;
   endtask

   task automatic meas(input int p0, input int p1, input int p2, input int p3);
      res_t r;
      int avg;
      avg = (p0 + p1 + p2 + p3) / 4;
      if (avg > ZH) begin
         r.period = 16'(avg);
         r.err = 1'b0;
         model_period = avg;
      end else begin
         r.period = 16'(model_period);
         r.err = 1'b1;
      end
      exp_q.push_back(r);
      run = 1'b1;
      tick(2);
      send_edges(p0, p1, p2, p3);
      wait_rdy("meas_done", 20);
      tick(3);
   endtask

   task automatic window_check(input string name, input int per, input int want_off);
      int lows0, a, b;
      logic [1:0] prev;
      lows0 = 0; a = -1; b = -1;
      prev = stb_o;
      for (int i = 0; i < 2 * per; i++) begin
         tick(1);
         if (!stb_o[0]) lows0++;
         if (a < 0 && prev[0] && !stb_o[0]) a = i;
         if (a >= 0 && b < 0 && prev[1] && !stb_o[1]) b = i;
         prev = stb_o;
      end
      check({name, "_ch0_lows"}, lows0, 2 * ZH);
      check({name, "_ch0_fall_seen"}, 32'(a >= 0), 1);
      check({name, "_ch1_offset"}, (b - a + per) % per, want_off);
   endtask

   initial begin
      int n, base, ph0, ph1;
      bit got;
      res_t r;
      do_reset();

      // Idle after reset: strobes all high, no period.
      oe = 2'b11;
      tick(20);
      check("idle_rdy", 32'(rdy_o), 1);
      check("idle_period", 32'(stb_period_o), 0);

      // Period 40 with ch1 phase 10, then phase 50 (out of range, treated as 0).
      phase = {16'd10, 16'd0};
      meas(40, 40, 40, 40);
      tick(5);
      window_check("ph10", 40, 10);
      phase = {16'd50, 16'd0};
      tick(45);
      window_check("ph50", 40, 0);

      meas(40, 41, 40, 42);
      meas(6, 6, 6, 6);
      meas(5, 6, 5, 6);
      meas(4, 4, 4, 4);
      meas(30, 30, 30, 30);

      // Static sig_i: timeout 1000 cycles after entering ARM.
      r.period = 16'(model_period);
      r.err = 1'b1;
      exp_q.push_back(r);
      run = 1'b1;
      n = 0;
      got = 0;
      while (!got && n < 1100) begin
         tick(1);
         n++;
         if (rdy_o) got = 1;
      end
      run = 1'b0;
      check("timeout_lat", n, 1 + int'(TO));
      tick(60);

      // Abort by dropping run_det_i mid-measurement.
      r.period = 16'(model_period);
      r.err = 1'b0;
      exp_q.push_back(r);
      run = 1'b1;
      tick(2);
      sig = 1'b1; tick(20); sig = 1'b0; tick(20); sig = 1'b1; tick(10);
      run = 1'b0;
      sig = 1'b0;
      wait_rdy("abort_done", 5);
      tick(40);

      for (int it = 0; it < 8; it++) begin
         base = int'($urandom_range(8, 60));
         ph0  = int'($urandom_range(0, 70));
         ph1  = int'($urandom_range(0, 70));
         phase = {16'(ph1), 16'(ph0)};
         oe = 2'($urandom_range(0, 3));
         meas(base + int'($urandom_range(0, 2)), base + int'($urandom_range(0, 2)),
              base + int'($urandom_range(0, 2)), base + int'($urandom_range(0, 2)));
         tick(int'($urandom_range(5, 80)));
         oe = 2'($urandom_range(0, 3));
         phase = {16'($urandom_range(0, 70)), 16'($urandom_range(0, 70))};
         tick(int'($urandom_range(5, 80)));
      end
      check("sb_drain", exp_q.size(), 0);

      // Reset in the middle of a measurement discards it.
      oe = 2'b11;
      run = 1'b1;
      tick(2);
      sig = 1'b1; tick(20); sig = 1'b0; tick(20); sig = 1'b1; tick(8);
      do_reset();
      tick(30);
      check("post_rst_period", 32'(stb_period_o), 0);
      check("post_rst_rdy", 32'(rdy_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
